// File: rtl/iir_cascade_tdm_if.sv
// Sample stream and coefficient/control bus of the time-multiplexed biquad cascade.
// Handshake: a sample transfers on a rising edge where in_valid && in_ready; out_valid is a one-cycle pulse, no back-pressure.
interface iir_cascade_tdm_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ADDR_W      = 5
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  x_in;
    logic                          out_valid;
    logic signed [DATA_WIDTH-1:0]  y_out;
    logic                          coef_we;
    logic [ADDR_W-1:0]             coef_addr;
    logic signed [COEFF_WIDTH-1:0] coef_wdata;
    logic                          state_clr;
    logic                          sat_flag;

    modport master (
        output in_valid, x_in, coef_we, coef_addr, coef_wdata, state_clr,
        input  in_ready, out_valid, y_out, sat_flag
    );

    modport slave (
        input  in_valid, x_in, coef_we, coef_addr, coef_wdata, state_clr,
        output in_ready, out_valid, y_out, sat_flag
    );
endinterface

// File: rtl/iir_cascade_tdm.sv
// N-section DF2T biquad cascade sharing one datapath, one section per cycle.
// Coefficients are Q(COEFF_FRAC); section states are kept pre-scaled by 2^COEFF_FRAC.
module iir_cascade_tdm #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 14,
    parameter int NUM_STAGES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_cascade_tdm_if.slave     bus,
    output logic                 fsm_dbg
);
    localparam int ADDR_W = $clog2(5 * NUM_STAGES);
    localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + 2;
    localparam int W      = ACC_W + 2;
    localparam int K_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic signed [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(1) << COEFF_FRAC;
    localparam logic signed [DATA_WIDTH-1:0]  D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0]  D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]       A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]       A_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t           state_q, state_d;
    logic [K_W-1:0] k_q, k_d;

    logic signed [COEFF_WIDTH-1:0] coef [NUM_STAGES][5];
    logic signed [ACC_W-1:0]       s1 [NUM_STAGES];
    logic signed [ACC_W-1:0]       s2 [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0]  d_q;
    logic signed [DATA_WIDTH-1:0]  y_out_q;
    logic                          out_valid_q;
    logic                          sat_q;

    logic accept, clr_now, last;

    function automatic logic signed [W-1:0] ext_d(input logic signed [DATA_WIDTH-1:0] v);
        return {{(W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] ext_c(input logic signed [COEFF_WIDTH-1:0] v);
        return {{(W-COEFF_WIDTH){v[COEFF_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] ext_a(input logic signed [ACC_W-1:0] v);
        return {{(W-ACC_W){v[ACC_W-1]}}, v};
    endfunction

    assign bus.in_ready  = (state_q == IDLE) && !bus.state_clr;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_out_q;
    assign bus.sat_flag  = sat_q;
    assign fsm_dbg       = (state_q == RUN);

    assign accept  = bus.in_valid && (state_q == IDLE) && !bus.state_clr;
    assign clr_now = bus.state_clr && (state_q == IDLE);
    assign last    = (k_q == K_W'(NUM_STAGES - 1));

    // Shared section datapath, selected by k_q.
    logic signed [W-1:0]          d_w, y_w, acc, sh, s1_sum, s2_sum;
    logic signed [DATA_WIDTH-1:0] y;
    logic signed [ACC_W-1:0]      s1_next, s2_next;
    logic                         clip_y, clip_s1, clip_s2;

    always_comb begin
        d_w    = ext_d(d_q);
        acc    = ext_c(coef[k_q][0]) * d_w + ext_a(s1[k_q]);
        sh     = acc >>> COEFF_FRAC;
        clip_y = !((&sh[W-1:DATA_WIDTH-1]) || !(|sh[W-1:DATA_WIDTH-1]));
        y      = clip_y ? (sh[W-1] ? D_MIN : D_MAX) : sh[DATA_WIDTH-1:0];
        y_w    = ext_d(y);

        s1_sum  = ext_c(coef[k_q][1]) * d_w - ext_c(coef[k_q][3]) * y_w + ext_a(s2[k_q]);
        s2_sum  = ext_c(coef[k_q][2]) * d_w - ext_c(coef[k_q][4]) * y_w;
        clip_s1 = !((&s1_sum[W-1:ACC_W-1]) || !(|s1_sum[W-1:ACC_W-1]));
        clip_s2 = !((&s2_sum[W-1:ACC_W-1]) || !(|s2_sum[W-1:ACC_W-1]));
        s1_next = clip_s1 ? (s1_sum[W-1] ? A_MIN : A_MAX) : s1_sum[ACC_W-1:0];
        s2_next = clip_s2 ? (s2_sum[W-1] ? A_MIN : A_MAX) : s2_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (last) state_d = IDLE;
                else      k_d     = k_q + K_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes land at the edge, so a section computed this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_STAGES; s++)
                for (int i = 0; i < 5; i++)
                    coef[s][i] <= (i == 0) ? COEFF_ONE : '0;
        end else if (bus.coef_we) begin
            for (int s = 0; s < NUM_STAGES; s++)
                for (int i = 0; i < 5; i++)
                    if (bus.coef_addr == ADDR_W'(5 * s + i))
                        coef[s][i] <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q         <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                s1[s] <= '0;
                s2[s] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (accept) d_q <= bus.x_in;
            if (state_q == RUN) begin
                d_q     <= y;
                s1[k_q] <= s1_next;
                s2[k_q] <= s2_next;
                if (clip_y || clip_s1 || clip_s2) sat_q <= 1'b1;
                if (last) begin
                    y_out_q     <= y;
                    out_valid_q <= 1'b1;
                end
            end
            if (clr_now) begin
                sat_q <= 1'b0;
                for (int s = 0; s < NUM_STAGES; s++) begin
                    s1[s] <= '0;
                    s2[s] <= '0;
                end
            end
        end
    end
endmodule

// File: doc/iir_cascade_tdm.md
Name: iir_cascade_tdm

Overview:
- Parametrised N-section cascade of DF2T biquad IIR sections. One shared biquad datapath is time-multiplexed across all sections.
- Coefficients live in a runtime-writable register file; per-section delay states are held in registers.
- Input and output use a valid/ready sample handshake. The block replaces fixed two-section cascades in the filter chain, with saturation, state clearing and an overflow flag added.

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement)
- COEFF_WIDTH, 16, coefficient width (signed)
- COEFF_FRAC, 14, fractional bits of coefficients (Q2.14 at defaults; 1.0 = 16384)
- NUM_STAGES, 4, number of biquad sections (>=1)
- Local parameters:
  - ADDR_W = $clog2(5*NUM_STAGES)
  - ACC_W = DATA_WIDTH+COEFF_WIDTH+2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- x_in  in  DATA_WIDTH  signed input sample
- out_valid  out  1  one-cycle pulse, y_out updated
- y_out  out  DATA_WIDTH  signed filtered sample, held between pulses
- coef_we  in  1  coefficient write strobe
- coef_addr  in  ADDR_W  coefficient address = 5*stage + idx (idx 0..4 = b0,b1,b2,a1,a2)
- coef_wdata  in  COEFF_WIDTH  signed coefficient value
- state_clr  in  1  zero all section states and sat_flag
- sat_flag  out  1  sticky: any saturation since last clear/reset

Behaviour:
- Reset (rst low at posedge):
  - FSM=IDLE, out_valid=0, y_out=0, sat_flag=0, all states s1/s2=0.
  - Coefficients reset to passthrough: b0=1<<COEFF_FRAC, all others 0.
- FSM states: IDLE, RUN. Stage counter k runs 0..NUM_STAGES-1.
- in_ready = (FSM==IDLE) && !state_clr, combinational.
- Accept: in_valid && in_ready at posedge T. x_in is latched into the stage data register, k=0, FSM->RUN.
- RUN: one section per cycle, on cycles T+1 .. T+NUM_STAGES. Section k operates on data register d:
  - acc = b0*d + s1[k] (full precision).
  - y = sat_DATA(acc >>> COEFF_FRAC): arithmetic shift, truncation toward -inf.
  - s1[k] <= sat_ACC(b1*d - a1*y + s2[k]).
  - s2[k] <= sat_ACC(b2*d - a2*y).
  - d <= y.
  - Denominator convention: 1 + a1 z^-1 + a2 z^-2.
  - States are stored pre-scaled, i.e. in units of 2^-COEFF_FRAC, ACC_W bits.
- Last section (k==NUM_STAGES-1):
  - y_out <= y and out_valid=1 during cycle T+NUM_STAGES+1.
  - FSM->IDLE, so in_ready is high again in that same cycle.
  - Latency accept→out_valid = NUM_STAGES+1 cycles; max throughput = 1 sample per NUM_STAGES+1 cycles.
- Saturation: any clip of y or a state sets sat_flag. It stays set until state_clr is honoured or reset.
- Coefficient writes:
  - Accepted in any FSM state and take effect at the next edge.
  - A write to the section being computed in the same cycle: that computation uses the old value.
  - Addresses >= 5*NUM_STAGES are ignored.
- state_clr:
  - Honoured only in IDLE: clears s1/s2 of all sections and sat_flag; coefficients and y_out are unchanged.
  - In RUN it is ignored (no latching); the host must hold it until in_ready would rise.
  - state_clr and in_valid together: the clear wins and no sample is accepted.
- Reset mid-RUN aborts the sample: no out_valid, all state returns to reset values.
- out_valid is never asserted except on a section-chain completion.

Test Plan:
- Reset passthrough, defaults: accept x_in=1000 at cycle T -> out_valid exactly at T+5, y_out=1000. Then x_in=-32768 -> y_out=-32768, sat_flag=0.
- FIR section: stage0 b0=b1=8192, others passthrough. Impulse 16384 then zeros -> outputs 8192, 8192, 0, 0.
- Recursion: stage0 b0=16384, a1=-8192. Impulse 16000 then zeros -> outputs 16000, 8000, 4000, 2000, 1000.
- Saturation: stage0 b0=32767, x_in=32767 -> y_out=32767, sat_flag=1. Then state_clr in IDLE -> sat_flag=0.
- Handshake:
  - in_valid held high continuously -> in_ready low during RUN and exactly one acceptance per 5 cycles.
  - state_clr asserted together with in_valid -> no acceptance that cycle; the recursion test afterward restarts at 16000.
- Reset mid-RUN at T+2 -> no out_valid, coefficients back to passthrough; next sample 500 -> y_out=500.
